// File: rtl/inst_rom_arb.sv
// inst_rom_arb: shares the single-port instruction ROM between CPU fetch and a debug/loader port.
// Define INST_ROM_ARB_FAIRNESS_EN to enable the debug starvation guard; otherwise fetch has strict priority.
module inst_rom_arb #(
  parameter int unsigned MEM_WORDS    = 131071,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_valid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  localparam logic [31:0] WORDS_L = 32'(MEM_WORDS);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("inst_rom_arb: STARVE_LIMIT must be in 1..255");
  end

  logic        starve_fire;
  logic        if_win;
  logic        dbg_win;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic [31:0] cap_rdata;

  logic        if_valid_q;
  logic [31:0] if_rdata_q;
  logic        if_err_q;
  logic        dbg_valid_q;
  logic [31:0] dbg_rdata_q;
  logic        dbg_err_q;

  // Grants are forced low while reset is held so the ROM stays disabled.
  always_comb begin
    dbg_win   = rst && dbg_req && (!if_req || starve_fire);
    if_win    = rst && if_req && !dbg_win;
    sel_addr  = dbg_win ? dbg_addr : if_addr;
    sel_err   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= WORDS_L);
    rom_ce    = (if_win || dbg_win) && !sel_err;
    rom_addr  = rom_ce ? sel_addr : 32'h0;
    cap_rdata = sel_err ? 32'h0 : rom_inst;
  end

  assign if_gnt  = if_win;
  assign dbg_gnt = dbg_win;

`ifdef INST_ROM_ARB_FAIRNESS_EN
  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_L = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  assign starve_fire = (wait_cnt_q == LIMIT_L);

  always_comb begin
    // NOTE: assigning a default before any condition keeps always_comb from inferring a latch.
    wait_cnt_d = '0;
    if (dbg_req && !dbg_win) begin
      wait_cnt_d = starve_fire ? LIMIT_L : wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  assign starve_fire = 1'b0;
`endif

  // The loser's data and error flag hold; only its valid drops.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      if_err_q    <= 1'b0;
      dbg_valid_q <= 1'b0;
      dbg_rdata_q <= 32'h0;
      dbg_err_q   <= 1'b0;
    end else begin
      if_valid_q  <= if_win;
      dbg_valid_q <= dbg_win;
      if (if_win) begin
        if_rdata_q <= cap_rdata;
        if_err_q   <= sel_err;
      end
      if (dbg_win) begin
        dbg_rdata_q <= cap_rdata;
        dbg_err_q   <= sel_err;
      end
    end
  end

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dbg_valid = dbg_valid_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_err   = dbg_err_q;

endmodule

// File: doc/inst_rom_arb.md
# inst_rom_arb

Two-port arbiter sharing the single-port instruction ROM between the CPU fetch stage and a debug/loader read port. Each cycle it selects at most one requester, drives the ROM chip-enable and address, range-checks the address, and returns registered read data tagged to the winner one cycle later. A starvation guard bounds the debug port's wait under continuous fetch traffic.

## Interface
- `MEM_WORDS`, 131071: number of 32-bit ROM words; word index is `addr[31:2]`.
- `STARVE_LIMIT`, 4: consecutive lost cycles after which the debug port wins. Range 1..255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; 0 = reset.
- `if_req`  in  1  fetch read request, level.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_valid`  out  1  `if_rdata`/`if_err` valid (registered).
- `if_rdata`  out  32  fetch read data.
- `if_err`  out  1  fetch address misaligned or out of range.
- `dbg_req`, `dbg_addr`, `dbg_gnt`, `dbg_valid`, `dbg_rdata`, `dbg_err`: same as the `if_*` signals, for the debug port.
- `rom_ce`  out  1  ROM chip-enable, 1 = enabled.
- `rom_addr`  out  32  ROM byte address.
- `rom_inst`  in  32  ROM read data, combinational from `rom_addr`/`rom_ce`.

## Operation
**Arbitration** (combinational, cycle N):
- Only `if_req` high: fetch wins.
- Only `dbg_req` high: debug wins.
- Both high: fetch wins, unless the starvation guard has fired (see Configuration), in which case debug wins.
- Exactly one `*_gnt` is high, and only for the winner.

**Address check** for the winner:
- `err = (addr[1:0] != 0) || (addr[31:2] >= MEM_WORDS)`.
- If `err`: `rom_ce = 0`, `rom_addr = 0`.
- Otherwise: `rom_ce = 1`, `rom_addr` = the winner's address.
- No winner: `rom_ce = 0`, `rom_addr = 0`.

**Capture** (edge ending cycle N):
- Winner `*_valid <= 1`.
- `*_rdata <= err ? 0 : rom_inst`.
- `*_err <= err`.
- Loser `*_valid <= 0`; its `rdata`/`err` hold their previous values.

**Handshake:**
- A requester holds `req` and `addr` stable until it sees `gnt`.
- `req` sampled with `gnt` high completes the transfer.
- Holding `req` after `gnt` is a new request; back-to-back transfers at one per cycle are legal.
- Address change while `req` is high and `gnt` is low: the arbiter uses the current value each cycle, with no error.

**Starvation counter `wait_cnt`**, width `$clog2(STARVE_LIMIT+1)`:
- Increments when `dbg_req && !dbg_gnt`.
- Clears when `dbg_gnt` or `!dbg_req`.
- Saturates at `STARVE_LIMIT`.
- Guard fires when `wait_cnt == STARVE_LIMIT`.

**Reset**, any time including mid-transfer:
- `*_valid`, `*_rdata`, `*_err`, `wait_cnt` go to 0 immediately.
- While `rst == 0`: `*_gnt = 0`, `rom_ce = 0`, `rom_addr = 0`.
- In-flight data is discarded; requesters reissue after reset.

## Timing
- Grant latency: 0 cycles; `gnt` is in the same cycle as `req` when uncontended.
- Data latency: 1 cycle; `*_valid` is high in cycle N+1 for a grant in cycle N.
- `*_valid` is a single-cycle pulse per grant; consecutive grants give continuous `valid`.
- Throughput: one access per cycle total.
- Worst-case debug wait with the guard: `STARVE_LIMIT` cycles, then granted in the next cycle.
- Combinational path: `req`/`addr` → `gnt`, `rom_addr` → `rom_inst` → capture register. No path from `rom_inst` to any output within the same cycle.
- Deassertion of `rst` is synchronized externally; the first grant is possible in the first cycle after release.

## Configuration
- `INST_ROM_ARB_FAIRNESS_EN` defined: starvation counter and guard present as described.
- Not defined: strict fetch priority. `wait_cnt` logic is omitted, and debug wins only in cycles with `if_req == 0`. `STARVE_LIMIT` is ignored.

## Test plan
- **Reset:** `rst = 0` asserted mid-transfer with `if_req = 1` → `if_gnt = 0`, `rom_ce = 0`, all `valid`/`rdata`/`err` = 0 within the same cycle. After release, fetch of `0x0` → `if_valid` one cycle later with `if_rdata = ROM[0]`.
- **Single port:** fetch of `0x0`, `0x4`, `0x8` back-to-back → `if_gnt` high in 3 cycles, `if_valid` high in the next 3 cycles, with data `ROM[0..2]` in order and `dbg_valid = 0`.
- **Contention:** `if_req` and `dbg_req` held high, `STARVE_LIMIT = 4`, macro defined → fetch granted cycles 0–3, debug granted cycle 4, fetch again from cycle 5. Macro undefined → debug never granted until `if_req` drops, then granted that same cycle.
- **Errors:** `dbg_addr = 0x2` → `dbg_err = 1`, `dbg_rdata = 0`, `rom_ce = 0`. `if_addr = MEM_WORDS*4` → `if_err = 1`, `if_rdata = 0`. `if_addr = (MEM_WORDS-1)*4` → `if_err = 0`, data = last word.
- **Independence:** debug transfer while fetch is idle → `dbg_valid` pulse, and `if_rdata` keeps its prior value unchanged.
